// File: rtl/psram_hdmi_fill.sv
// Keeps the 4-block HDMI display FIFO topped up with 64-byte PSRAM read bursts,
// walking a frame buffer block by block and wrapping at the end of each frame.
module psram_hdmi_fill #(
  parameter int unsigned FRAME_BLOCKS = 28800,
  parameter int unsigned PREFILL      = 4
) (
  input  logic        psramclk,
  input  logic        rst_psclk,
  input  logic        start_hdmi,
  input  logic        stop_hdmi,
  input  logic [22:0] fb_base,
  input  logic        fifo_rpt_update_hdclk,
  output logic        rd_req,
  output logic [22:0] rd_addr,
  input  logic        rd_ack,
  input  logic        rd_valid,
  input  logic [31:0] rd_data,
  output logic        fifo_wen,
  output logic [5:0]  fifo_wadr,
  output logic [31:0] fifo_wdata,
  output logic        fifo_empty,
  output logic        fill_busy
);
  localparam int unsigned ADDR_W      = 23;
  localparam int unsigned WADR_W      = 6;
  localparam int unsigned BEAT_W      = 4;
  localparam int unsigned LVL_W       = 3;
  localparam int unsigned FIFO_BLOCKS = 4;
  localparam int unsigned BLK_W       = (FRAME_BLOCKS > 1) ? $clog2(FRAME_BLOCKS) : 1;

  localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_BLOCKS);
  localparam logic [LVL_W-1:0]  LVL_PRE    = LVL_W'(PREFILL);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(FRAME_BLOCKS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(15);
  localparam logic [ADDR_W-1:0] BLK_BYTES  = ADDR_W'(64);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT} state_e;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [WADR_W-1:0] wadr, wadr_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [BLK_W-1:0]  blk_cnt, blk_nxt;
  logic [LVL_W-1:0]  level, level_nxt;
  logic              prefilled, prefilled_nxt;
  logic              stop_pend, stop_pend_nxt;
  logic              empty_q, empty_nxt;
  logic              start_prev;
  logic              sync1, sync2, sync3;
  logic              start_edge, free_evt, blk_done, frame_wrap;
  logic [ADDR_W-1:0] base_blk;
  logic              unused_fb_lsb;

  assign base_blk      = {fb_base[22:6], 6'b0};
  assign unused_fb_lsb = ^fb_base[5:0];
  assign start_edge    = start_hdmi & ~start_prev;
  assign free_evt      = sync2 & ~sync3;
  assign fifo_empty    = empty_q;

  // State and bookkeeping registers
  always_ff @(posedge psramclk or posedge rst_psclk) begin
    if (rst_psclk) begin
      state      <= IDLE;
      addr       <= '0;
      wadr       <= '0;
      beat       <= '0;
      blk_cnt    <= '0;
      level      <= '0;
      prefilled  <= 1'b0;
      stop_pend  <= 1'b0;
      empty_q    <= 1'b1;
      start_prev <= 1'b0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr       <= addr_nxt;
      wadr       <= wadr_nxt;
      beat       <= beat_nxt;
      blk_cnt    <= blk_nxt;
      level      <= level_nxt;
      prefilled  <= prefilled_nxt;
      stop_pend  <= stop_pend_nxt;
      empty_q    <= empty_nxt;
      start_prev <= start_hdmi;
      sync1      <= fifo_rpt_update_hdclk;
      sync2      <= sync1;
      sync3      <= sync2;
    end
  end

  // Next-state, FIFO write path and occupancy tracking
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    wadr_nxt      = wadr;
    beat_nxt      = beat;
    blk_nxt       = blk_cnt;
    level_nxt     = level;
    prefilled_nxt = prefilled;
    stop_pend_nxt = stop_pend;
    blk_done      = 1'b0;
    frame_wrap    = 1'b0;
    fifo_wen      = 1'b0;
    fifo_wdata    = '0;
    fifo_wadr     = wadr;
    rd_req        = (state == REQ);
    rd_addr       = addr;
    fill_busy     = (state != IDLE);

    case (state)
      IDLE: begin
        wadr_nxt      = '0;
        beat_nxt      = '0;
        blk_nxt       = '0;
        stop_pend_nxt = 1'b0;
        if (start_edge) begin
          addr_nxt  = base_blk;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rd_ack) state_nxt = DATA;
      end
      DATA: begin
        if (rd_valid) begin
          fifo_wen   = 1'b1;
          fifo_wdata = rd_data;
          wadr_nxt   = wadr + WADR_W'(1);
          beat_nxt   = beat + BEAT_W'(1);
          if (beat == BEAT_LAST) begin
            blk_done = 1'b1;
            if (blk_cnt == BLK_LAST) begin
              frame_wrap = 1'b1;
              blk_nxt    = '0;
              addr_nxt   = base_blk;
            end else begin
              blk_nxt  = blk_cnt + BLK_W'(1);
              addr_nxt = addr + BLK_BYTES;
            end
            state_nxt = (stop_pend && frame_wrap) ? IDLE : WAIT;
          end
        end
      end
      WAIT: begin
        if (level < LVL_FULL) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE && stop_hdmi) stop_pend_nxt = 1'b1;

    // A completion and a free in the same cycle cancel out
    if (state == IDLE) begin
      level_nxt = '0;
    end else if (blk_done && !free_evt) begin
      if (level < LVL_FULL) level_nxt = level + LVL_W'(1);
    end else if (free_evt && !blk_done) begin
      if (level != '0) level_nxt = level - LVL_W'(1);
    end

    if (state == IDLE)             prefilled_nxt = 1'b0;
    else if (level_nxt == LVL_PRE) prefilled_nxt = 1'b1;

    empty_nxt = ~prefilled_nxt | (level_nxt == '0);
  end
endmodule

// File: tb/tb_psram_hdmi_fill.sv
// Scoreboard bench for psram_hdmi_fill: a block-level frame/FIFO model predicts
// burst addresses, FIFO writes and occupancy while a random PSRAM responder drives data.
`timescale 1ns/1ps
module tb_psram_hdmi_fill;
  localparam int unsigned FB  = 8;
  localparam int unsigned PF  = 4;
  localparam int          TMO = 3000;

  typedef struct packed {
    logic [5:0]  adr;
    logic [31:0] data;
  } wr_t;

  logic        psramclk;
  logic        rst_psclk;
  logic        start_hdmi;
  logic        stop_hdmi;
  logic [22:0] fb_base;
  logic        fifo_rpt_update_hdclk;
  logic        rd_req;
  logic [22:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        fifo_wen;
  logic [5:0]  fifo_wadr;
  logic [31:0] fifo_wdata;
  logic        fifo_empty;
  logic        fill_busy;

  int checks   = 0;
  int failures = 0;

  logic [22:0] exp_req_q[$];
  wr_t         exp_wr_q[$];

  // Reference model state (block granularity)
  logic [22:0] m_base      = '0;
  int          m_blk       = 0;
  int          m_wadr      = 0;
  int          m_level     = 0;
  bit          m_prefilled = 0;
  bit          m_stop_pend = 0;
  bit          m_running   = 0;
  int          comp_cnt    = 0;
  int          words_total = 0;
  int          req_cnt     = 0;

  bit resp_en  = 1;
  bit stray_en = 1;
  bit held     = 0;
  int hold_at  = -1;
  int r_phase  = 0;
  int r_words  = 0;

  psram_hdmi_fill #(.FRAME_BLOCKS(FB), .PREFILL(PF)) dut (
    .psramclk              (psramclk),
    .rst_psclk             (rst_psclk),
    .start_hdmi            (start_hdmi),
    .stop_hdmi             (stop_hdmi),
    .fb_base               (fb_base),
    .fifo_rpt_update_hdclk (fifo_rpt_update_hdclk),
    .rd_req                (rd_req),
    .rd_addr               (rd_addr),
    .rd_ack                (rd_ack),
    .rd_valid              (rd_valid),
    .rd_data               (rd_data),
    .fifo_wen              (fifo_wen),
    .fifo_wadr             (fifo_wadr),
    .fifo_wdata            (fifo_wdata),
    .fifo_empty            (fifo_empty),
    .fill_busy             (fill_busy)
  );

  initial begin
    psramclk = 1'b0;
    forever #5 psramclk = ~psramclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: actual=0x%0h required=none", name, act);
  endtask

  function automatic bit exp_empty();
    return !m_prefilled || (m_level == 0);
  endfunction

  task automatic complete_block();
    comp_cnt++;
    if (m_level < 4) m_level++;
    if (m_level == int'(PF)) m_prefilled = 1;
    m_blk++;
    if (m_blk == int'(FB)) begin
      m_blk  = 0;
      m_base = fb_base & 23'h7fffc0;
      if (m_stop_pend) begin
        m_running   = 0;
        m_level     = 0;
        m_prefilled = 0;
        m_stop_pend = 0;
      end
    end
  endtask

  // PSRAM responder: random ack latency, random gaps between words, stray valids when idle
  initial begin
    rd_ack   = 1'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge psramclk);
      #2;
      rd_ack   = 1'b0;
      rd_valid = 1'b0;
      if (rst_psclk) begin
        r_phase = 0;
        r_words = 0;
        held    = 0;
      end else if (r_phase == 0) begin
        if (rd_req && resp_en && $urandom_range(2) != 0) begin
          rd_ack = 1'b1;
          req_cnt++;
          if (m_running) exp_req_q.push_back(m_base + 23'(m_blk * 64));
          r_phase = 1;
          r_words = 0;
        end else if (stray_en && $urandom_range(1) == 1) begin
          rd_valid = 1'b1;
          rd_data  = $urandom;
        end
      end else begin
        if (r_words == hold_at) begin
          held = 1;
        end else if (held || $urandom_range(3) != 0) begin
          held     = 0;
          rd_valid = 1'b1;
          rd_data  = $urandom;
          exp_wr_q.push_back('{adr: 6'(m_wadr), data: rd_data});
          m_wadr = (m_wadr + 1) % 64;
          r_words++;
          words_total++;
          if (r_words == 16) begin
            r_phase = 0;
            complete_block();
          end
        end
      end
    end
  end

  // Monitor: pops expected requests/writes whenever the DUT presents them
  logic        prev_pend = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [22:0] prev_addr = '0;
  always @(negedge psramclk) begin
    if (rst_psclk) begin
      prev_pend = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (prev_pend) begin
        check("req_held_until_ack", 32'(rd_req), 32'd1);
        check("req_addr_stable", 32'(rd_addr), 32'(prev_addr));
      end
      if (prev_ack) check("req_drop_after_ack", 32'(rd_req), 32'd0);
      if (rd_req && rd_ack) begin
        if (exp_req_q.size() == 0) fail_now("unexpected_req", 32'(rd_addr));
        else check("rd_addr", 32'(rd_addr), 32'(exp_req_q.pop_front()));
      end
      if (fifo_wen) begin
        if (exp_wr_q.size() == 0) begin
          fail_now("unexpected_write", 32'(fifo_wadr));
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          check("fifo_wadr", 32'(fifo_wadr), 32'(e.adr));
          check("fifo_wdata", fifo_wdata, e.data);
        end
      end
      prev_pend = rd_req && !rd_ack;
      prev_ack  = rd_req && rd_ack;
      prev_addr = rd_addr;
    end
  end

  task automatic wait_comp(input int n, input string name);
    int i = 0;
    while (comp_cnt < n && i < TMO) begin
      @(negedge psramclk);
      i++;
    end
    check(name, 32'(comp_cnt >= n), 32'd1);
  endtask

  task automatic wait_words(input int n, input string name);
    int i = 0;
    while (words_total < n && i < TMO) begin
      @(negedge psramclk);
      i++;
    end
    check(name, 32'(words_total >= n), 32'd1);
  endtask

  task automatic wait_held(input string name);
    int i = 0;
    while (!held && i < TMO) begin
      @(negedge psramclk);
      i++;
    end
    check(name, 32'(held), 32'd1);
  endtask

  task automatic wait_req(input int n, input string name);
    int i = 0;
    while (req_cnt < n && i < TMO) begin
      @(negedge psramclk);
      i++;
    end
    check(name, 32'(req_cnt >= n), 32'd1);
  endtask

  task automatic quiet_window(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge psramclk);
      if (rd_req) hi++;
    end
  endtask

  task automatic free_pulse();
    @(posedge psramclk);
    #1;
    fifo_rpt_update_hdclk = 1'b1;
    if (m_running && m_level > 0) m_level--;
    repeat (4) @(posedge psramclk);
    #1;
    fifo_rpt_update_hdclk = 1'b0;
    repeat (4) @(posedge psramclk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rd_req"},     32'(rd_req),     32'd0);
    check({tag, "_rd_addr"},    32'(rd_addr),    32'd0);
    check({tag, "_fifo_wen"},   32'(fifo_wen),   32'd0);
    check({tag, "_fifo_wadr"},  32'(fifo_wadr),  32'd0);
    check({tag, "_fifo_wdata"}, fifo_wdata,      32'd0);
    check({tag, "_fifo_empty"}, 32'(fifo_empty), 32'd1);
    check({tag, "_fill_busy"},  32'(fill_busy),  32'd0);
  endtask

  task automatic start_frame(input logic [22:0] base);
    @(posedge psramclk);
    #1;
    fb_base     = base;
    start_hdmi  = 1'b1;
    m_base      = base & 23'h7fffc0;
    m_blk       = 0;
    m_wadr      = 0;
    m_level     = 0;
    m_prefilled = 0;
    m_stop_pend = 0;
    m_running   = 1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int base_cnt;
    rst_psclk             = 1'b1;
    start_hdmi            = 1'b0;
    stop_hdmi             = 1'b0;
    fb_base               = 23'h100000;
    fifo_rpt_update_hdclk = 1'b0;

    repeat (3) @(posedge psramclk);
    #1;
    reset_checks("por");
    rst_psclk = 1'b0;
    repeat (3) @(posedge psramclk);

    // Prefill four blocks from 0x100000
    start_frame(23'h100000);
    wait_words(63, "prefill_63_words");
    check("prefill_empty_before_64th", 32'(fifo_empty), 32'd1);
    wait_comp(4, "prefill_4_blocks");
    repeat (3) @(negedge psramclk);
    check("prefill_empty_after", 32'(fifo_empty), 32'(exp_empty()));
    check("prefill_level", 32'(dut.level), 32'(m_level));
    quiet_window(30, hi);
    check("prefill_no_req_when_full", 32'(hi), 32'd0);

    // One free -> exactly one refill burst
    base_cnt = req_cnt;
    free_pulse();
    check("refill_empty_low", 32'(fifo_empty), 32'(exp_empty()));
    wait_comp(5, "refill_block");
    quiet_window(30, hi);
    check("refill_one_req", 32'(req_cnt - base_cnt), 32'd1);
    check("refill_empty_after", 32'(fifo_empty), 32'(exp_empty()));

    // Free coincident with the 16th word at level 3, then stop at frame end
    hold_at = 15;
    free_pulse();
    wait_held("coinc_hold_15");
    stop_hdmi   = 1'b1;
    m_stop_pend = 1;
    base_cnt    = req_cnt;
    @(posedge psramclk);
    #1;
    fifo_rpt_update_hdclk = 1'b1;
    if (m_level > 0) m_level--;
    @(posedge psramclk);
    #1;
    @(posedge psramclk);
    #1;
    hold_at = -1;
    @(posedge psramclk);
    #1;
    @(posedge psramclk);
    #1;
    fifo_rpt_update_hdclk = 1'b0;
    repeat (4) @(posedge psramclk);
    @(negedge psramclk);
    check("coinc_level_kept", 32'(dut.level), 32'(m_level));
    wait_req(base_cnt + 1, "coinc_next_req");
    wait_comp(7, "stop_block6");
    free_pulse();
    wait_comp(8, "stop_block7");
    repeat (2) @(negedge psramclk);
    quiet_window(30, hi);
    check("stop_no_req_at_base", 32'(hi), 32'd0);
    check("stop_fill_busy", 32'(fill_busy), 32'd0);
    check("stop_fifo_empty", 32'(fifo_empty), 32'(exp_empty()));
    check("stop_req_queue", 32'(exp_req_q.size()), 32'd0);
    stop_hdmi = 1'b0;

    // Restart at a random base, ignore a start re-edge, then drain
    start_hdmi = 1'b0;
    repeat (3) @(posedge psramclk);
    start_frame(23'($urandom));
    @(posedge psramclk);
    #1;
    fb_base = 23'($urandom);
    repeat (5) @(posedge psramclk);
    #1;
    start_hdmi = 1'b0;
    repeat (3) @(posedge psramclk);
    #1;
    start_hdmi = 1'b1;
    wait_comp(12, "drain_prefill");
    resp_en = 0;
    repeat (3) @(negedge psramclk);
    repeat (3) free_pulse();
    check("drain_3_empty", 32'(fifo_empty), 32'(exp_empty()));
    free_pulse();
    check("drain_4_level", 32'(dut.level), 32'(m_level));
    check("drain_4_empty", 32'(fifo_empty), 32'(exp_empty()));
    free_pulse();
    check("drain_5_level", 32'(dut.level), 32'(m_level));
    check("drain_5_empty", 32'(fifo_empty), 32'(exp_empty()));

    // Reset in the middle of a burst after word 7
    hold_at = 7;
    resp_en = 1;
    wait_held("reset_hold_word7");
    check("reset_pre_wr_queue", 32'(exp_wr_q.size()), 32'd0);
    @(posedge psramclk);
    #1;
    rst_psclk  = 1'b1;
    start_hdmi = 1'b0;
    #1;
    reset_checks("midburst");
    m_running   = 0;
    m_level     = 0;
    m_prefilled = 0;
    m_stop_pend = 0;
    exp_req_q.delete();
    exp_wr_q.delete();
    hold_at = -1;
    repeat (2) @(posedge psramclk);
    #1;
    rst_psclk = 1'b0;
    repeat (12) @(negedge psramclk);
    check("post_reset_idle", 32'(fill_busy), 32'd0);
    base_cnt = comp_cnt;
    start_frame(23'($urandom));
    wait_comp(base_cnt + 4, "restart_prefill");
    repeat (3) @(negedge psramclk);
    check("restart_empty", 32'(fifo_empty), 32'(exp_empty()));
    check("restart_wr_queue", 32'(exp_wr_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psram_hdmi_fill.md
PSRAM_HDMI_FILL -- requirements
Module: psram_hdmi_fill

Interface
REQ-001 The module SHALL have parameter FRAME_BLOCKS, default 28800, meaning 64-byte blocks per frame (1280x720 RGB565).
REQ-002 The module SHALL have parameter PREFILL, default 4, meaning blocks resident before fifo_empty first deasserts (FIFO depth 4 x 64 bytes).
REQ-003 The module SHALL have one clock and an asynchronous active-high reset, with ports as follows:
  psramclk  in  1  sole clock
  rst_psclk  in  1  asynchronous, active-high reset
  start_hdmi  in  1  psramclk-synchronous level; rising edge starts filling
  stop_hdmi  in  1  psramclk-synchronous level; stop at next frame boundary
  fb_base  in  23  frame buffer byte address; bits [5:0] are treated as 0
  fifo_rpt_update_hdclk  in  1  hdmiclk-domain pulse (>=4 hdmiclk wide); each rising edge frees one block
  rd_req  out  1  PSRAM 64-byte read burst request
  rd_addr  out  23  burst byte address
  rd_ack  in  1  one-cycle request accept
  rd_valid  in  1  read data word valid
  rd_data  in  32  read data word (2 pixels)
  fifo_wen  out  1  FIFO write strobe
  fifo_wadr  out  6  FIFO word address [7:2]
  fifo_wdata  out  32  FIFO write data
  fifo_empty  out  1  display FIFO not ready / drained
  fill_busy  out  1  high whenever state != IDLE

Function
REQ-004 The module SHALL implement FSM states IDLE, REQ, DATA and WAIT.
REQ-005 IDLE: the module SHALL hold level=0, wadr=0, blk_cnt=0 and prefilled=0; on a start_hdmi rising edge (start_hdmi=1 and previous sample=0) it SHALL load addr=fb_base and go to REQ.
REQ-006 REQ: rd_req SHALL be 1 with rd_addr stable until the cycle rd_ack=1; rd_req SHALL drop the next cycle, and the state SHALL go to DATA.
REQ-007 DATA: each rd_valid=1 SHALL produce, in the same cycle, fifo_wen=1, fifo_wdata=rd_data and fifo_wadr=wadr; wadr SHALL then increment modulo 64.
REQ-008 On the 16th valid word of a burst, the module SHALL increment level and blk_cnt, and SHALL set addr = addr+64 (modulo 2^23).
REQ-009 If that block has blk_cnt == FRAME_BLOCKS-1, the module SHALL instead set blk_cnt=0 and reload addr=fb_base (frame wrap).
REQ-010 After the 16th word, the state SHALL go to WAIT, or to IDLE if stop_pend=1 and a frame wrap occurred.
REQ-011 rd_valid outside DATA SHALL be ignored, with no write.
REQ-012 WAIT: if level < 4, the state SHALL go to REQ the next cycle; otherwise it SHALL remain in WAIT.
REQ-013 The module SHALL synchronize fifo_rpt_update_hdclk through 2 flops plus 1 edge flop; a rising edge (sync2=1, sync3=0) SHALL be one "free" event.
REQ-014 A free event SHALL decrement level, saturating at 0.
REQ-015 A free event and a block completion in the same cycle SHALL leave level unchanged.
REQ-016 level SHALL never exceed 4, and level == 4 SHALL block new requests.
REQ-017 prefilled SHALL set when level first reaches PREFILL, and SHALL clear in IDLE.
REQ-018 fifo_empty SHALL be a registered output equal to ~prefilled | (level==0).
REQ-019 stop_hdmi=1 sampled in any non-IDLE state SHALL set stop_pend, and stop_pend SHALL clear in IDLE.
REQ-020 While stop_pend=1, a burst already in REQ or DATA SHALL complete normally.
REQ-021 start_hdmi edges outside IDLE SHALL be ignored.
REQ-022 fb_base SHALL be sampled only at start and at frame wrap.

Reset
REQ-023 When rst_psclk=1, all registers SHALL clear asynchronously, giving rd_req=0, rd_addr=0, fifo_wen=0, fifo_wadr=0, fifo_wdata=0, fifo_empty=1, fill_busy=0, state=IDLE, level=0 and stop_pend=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst, and after release the module SHALL await a new start_hdmi edge.
REQ-025 Synchronizer flops SHALL reset to 0.

Verification
REQ-026 The bench SHALL cover prefill: fb_base=0x100000, start edge, immediate rd_ack, 16 valids per burst -> rd_addr 0x100000, 0x100040, 0x100080, 0x1000C0; fifo_wadr 0..63; fifo_empty falls after the 64th word; rd_req then stays 0.
REQ-027 The bench SHALL cover free/refill: 1 rpt_update pulse -> exactly one new request at 0x100100, written to fifo_wadr 0..15 (wrap); fifo_empty stays 0.
REQ-028 The bench SHALL cover simultaneous events: a free edge coincident with a 16th word at level=3 -> level stays 3, and the next request issues.
REQ-029 The bench SHALL cover frame wrap and stop: FRAME_BLOCKS=8, stop_hdmi asserted at block 5 -> blocks 6 and 7 are fetched, no request at fb_base, IDLE reached, fifo_empty=1, fill_busy=0.
REQ-030 The bench SHALL cover drain: stop feeding rd_ack after prefill and apply 4 free edges -> level 0, fifo_empty=1; 5th edge -> level stays 0.
REQ-031 The bench SHALL cover reset mid-burst: rst_psclk asserted after word 7 -> all outputs at reset values immediately; rd_valid afterwards ignored; a fresh start restarts at fb_base with fifo_wadr=0.
